// File: rtl/i2c_seq_pkg.sv
// ----------------------------------------------------------------------------
// i2c_seq_pkg
// Shared definitions for the SSD1306 power-up sequencer:
//   - seq_state_t      : sequencer state encoding
//   - CTRL_CMD_STREAM  : SSD1306 control byte announcing a command stream
//   - SSD1306_INIT     : power-up command bytes, sent in array order
//   - BACKOFF_CYCLES   : idle gap before a retry (retry build only)
//   - WAIT_BUSY_CYCLES : how long the controller gets to raise busy
// ----------------------------------------------------------------------------
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        STREAM,
        WAIT_DONE,
        BACKOFF,
        DONE,
        ERROR
    } seq_state_t;

    localparam logic [7:0] CTRL_CMD_STREAM = 8'h00;

    localparam int INIT_LEN = 25;

    // 128x64 panel with internal charge pump.
    localparam logic [7:0] SSD1306_INIT [INIT_LEN] = '{
        8'hAE,          // display off
        8'hD5, 8'h80,   // clock divide / oscillator
        8'hA8, 8'h3F,   // multiplex ratio 64
        8'hD3, 8'h00,   // display offset 0
        8'h40,          // start line 0
        8'h8D, 8'h14,   // charge pump on
        8'h20, 8'h00,   // horizontal addressing
        8'hA1,          // segment remap
        8'hC8,          // COM scan descending
        8'hDA, 8'h12,   // COM pin config
        8'h81, 8'hCF,   // contrast
        8'hD9, 8'hF1,   // pre-charge period
        8'hDB, 8'h40,   // VCOMH deselect level
        8'hA4,          // follow RAM content
        8'hA6,          // normal (not inverted)
        8'hAF           // display on
    };

    localparam int BACKOFF_CYCLES   = 1024;
    localparam int WAIT_BUSY_CYCLES = 16;

endpackage

// File: rtl/i2c_cmd_rom.sv
// ----------------------------------------------------------------------------
// i2c_cmd_rom
// Combinational command table: maps a command index to its init byte.
// Indices past the end of the table read as 8'h00. Swap the package table
// to drive a different panel with the same sequencer.
//   addr  in  6  command index (0..63)
//   data  out 8  command byte at addr
// ----------------------------------------------------------------------------
module i2c_cmd_rom (
    input  logic [5:0] addr,
    output logic [7:0] data
);
    import i2c_seq_pkg::*;

    // NOTE: a constant lookup table holds no state, so there is nothing to reset.
    always_comb begin
        data = 8'h00;
        for (int i = 0; i < INIT_LEN; i++) begin
            if (addr == 6'(i)) data = SSD1306_INIT[i];
        end
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// ----------------------------------------------------------------------------
// i2c_init_sequencer
// Drives I2C_Controller through a single write transaction that powers up an
// SSD1306: device address, control byte 0x00, then NUM_CMDS ROM bytes chained
// with send_additional_data. Reports sticky done / error and keeps seq_busy
// high while the sequence owns the bus.
//
// Build option: define I2C_SEQ_RETRY_EN to retry a faulted transaction
// (after a BACKOFF_CYCLES quiet gap) up to MAX_RETRIES times before ERROR.
//
// Ports:
//   clk                   in   system clock (27 MHz)
//   reset                 in   synchronous, active-high
//   go                    in   launch request (level or pulse)
//   busy                  in   controller transaction in progress
//   NACK                  in   controller missing-ACK pulse
//   data_saved            in   controller latched data_in
//   start                 out  one-cycle start pulse
//   address_in            out  device write address
//   data_in               out  byte currently offered
//   send_additional_data  out  data_in holds an unsent byte
//   done                  out  sticky: sequence completed cleanly
//   error                 out  sticky: NACK or timeout, retries exhausted
//   seq_busy              out  sequence active (not IDLE/DONE/ERROR)
// ----------------------------------------------------------------------------
module i2c_init_sequencer #(
    parameter logic [7:0] DEV_ADDR       = 8'h78,
    parameter int         NUM_CMDS       = 25,
    parameter int         TIMEOUT_CYCLES = 2_700_000,
    parameter int         MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       busy,
    input  logic       NACK,
    input  logic       data_saved,
    output logic       start,
    output logic [7:0] address_in,
    output logic [7:0] data_in,
    output logic       send_additional_data,
    output logic       done,
    output logic       error,
    output logic       seq_busy
);
    import i2c_seq_pkg::*;

    localparam int IDX_W = $clog2(NUM_CMDS + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t       state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [7:0]       data_n;
    logic             sad_n, done_n, error_n;
    logic             fault, fault_n;      // NACK seen during this attempt
    logic [WD_W-1:0]  wd, wd_n;            // watchdog, cleared at LAUNCH
    logic             go_q;
    logic             active, resolve, launch, nack_seen;
    logic [5:0]       rom_addr;
    logic [7:0]       rom_byte;

`ifdef I2C_SEQ_RETRY_EN
    localparam int RT_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int BO_W = $clog2(BACKOFF_CYCLES);

    logic [RT_W-1:0] retry_cnt, retry_n;
    logic [BO_W-1:0] bo_cnt, bo_n;
`endif

    // Byte idx+1 is ROM[idx]; clamp so the ROM never sees an index past the table.
    assign rom_addr = (idx < IDX_W'(NUM_CMDS)) ? 6'(idx) : 6'(NUM_CMDS - 1);

    i2c_cmd_rom u_rom (
        .addr (rom_addr),
        .data (rom_byte)
    );

    assign active     = state inside {LAUNCH, WAIT_BUSY, STREAM, WAIT_DONE};
    assign nack_seen  = fault || NACK;
    assign start      = (state == LAUNCH);
    assign seq_busy   = !(state inside {IDLE, DONE, ERROR});
    assign address_in = DEV_ADDR;

    // NOTE: every variable gets its hold value first, so no path infers a latch.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        data_n  = data_in;
        sad_n   = send_additional_data;
        done_n  = done;
        error_n = error;
        fault_n = fault;
        wd_n    = wd;
        resolve = 1'b0;
        launch  = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
        retry_n = retry_cnt;
        bo_n    = bo_cnt;
`endif

        if (active) begin
            wd_n = wd + 1'b1;
            if (NACK) fault_n = 1'b1;
        end

        case (state)
            IDLE:      launch = go && !busy;
            LAUNCH:    state_n = WAIT_BUSY;
            WAIT_BUSY: begin
                if (busy) state_n = STREAM;
                else if (wd == WD_W'(WAIT_BUSY_CYCLES)) resolve = 1'b1;
            end
            STREAM: begin
                // A NACKed transaction is only resolved once the controller lets go.
                if (!busy && nack_seen) begin
                    resolve = 1'b1;
                end else if (data_saved) begin
                    if (idx < IDX_W'(NUM_CMDS)) begin
                        idx_n  = idx + 1'b1;
                        data_n = rom_byte;
                    end else begin
                        sad_n   = 1'b0;
                        state_n = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    if (nack_seen) begin
                        resolve = 1'b1;
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end
`ifdef I2C_SEQ_RETRY_EN
            BACKOFF: begin
                // The quiet gap restarts if anything else grabs the bus.
                if (busy) bo_n = '0;
                else if (bo_cnt == BO_W'(BACKOFF_CYCLES - 1)) launch = 1'b1;
                else bo_n = bo_cnt + 1'b1;
            end
`endif
            // Terminal: only a fresh go edge re-runs the sequence.
            DONE, ERROR: launch = go && !go_q && !busy;
            default:     state_n = IDLE;
        endcase

        // Watchdog fires regardless of what the controller is doing.
        if (active && wd == WD_W'(TIMEOUT_CYCLES - 1)) resolve = 1'b1;

        if (resolve) begin
            sad_n  = 1'b0;
            done_n = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
            if (retry_cnt == RT_W'(MAX_RETRIES)) begin
                state_n = ERROR;
                error_n = 1'b1;
            end else begin
                state_n = BACKOFF;
                bo_n    = BO_W'(1);   // the fault cycle itself had busy=0
            end
`else
            state_n = ERROR;
            error_n = 1'b1;
`endif
        end

        if (launch) begin
            state_n = LAUNCH;
            idx_n   = '0;
            data_n  = CTRL_CMD_STREAM;
            sad_n   = 1'b1;
            fault_n = 1'b0;
            wd_n    = '0;
            done_n  = 1'b0;
            error_n = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
            retry_n = (state == BACKOFF) ? retry_cnt + 1'b1 : '0;
`endif
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            idx                  <= '0;
            data_in              <= 8'h00;
            send_additional_data <= 1'b0;
            done                 <= 1'b0;
            error                <= 1'b0;
            fault                <= 1'b0;
            wd                   <= '0;
            go_q                 <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
            retry_cnt            <= '0;
            bo_cnt               <= '0;
`endif
        end else begin
            state                <= state_n;
            idx                  <= idx_n;
            data_in              <= data_n;
            send_additional_data <= sad_n;
            done                 <= done_n;
            error                <= error_n;
            fault                <= fault_n;
            wd                   <= wd_n;
            go_q                 <= go;
`ifdef I2C_SEQ_RETRY_EN
            retry_cnt            <= retry_n;
            bo_cnt               <= bo_n;
`endif
        end
    end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// ----------------------------------------------------------------------------
// tb_i2c_init_sequencer
// Behavioural I2C controller model + byte scoreboard for i2c_init_sequencer.
// A second instance with a short watchdog covers the timeout path.
// ----------------------------------------------------------------------------
module tb_i2c_init_sequencer;

    localparam int NUM_CMDS   = 25;
    localparam int TO_CYCLES  = 5000;
    localparam int ADDR_NACK  = -2;
    localparam int START_WAIT = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, go, busy, nack, data_saved;
    logic       start, send_additional_data, done, error, seq_busy;
    logic [7:0] address_in, data_in;

    logic       t_go, t_busy;
    logic       t_start, t_sad, t_done, t_error, t_seq_busy;
    logic [7:0] t_address_in, t_data_in;

    i2c_init_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .go                   (go),
        .busy                 (busy),
        .NACK                 (nack),
        .data_saved           (data_saved),
        .start                (start),
        .address_in           (address_in),
        .data_in              (data_in),
        .send_additional_data (send_additional_data),
        .done                 (done),
        .error                (error),
        .seq_busy             (seq_busy)
    );

    i2c_init_sequencer #(.TIMEOUT_CYCLES(TO_CYCLES), .MAX_RETRIES(0)) dut_to (
        .clk                  (clk),
        .reset                (reset),
        .go                   (t_go),
        .busy                 (t_busy),
        .NACK                 (1'b0),
        .data_saved           (1'b0),
        .start                (t_start),
        .address_in           (t_address_in),
        .data_in              (t_data_in),
        .send_additional_data (t_sad),
        .done                 (t_done),
        .error                (t_error),
        .seq_busy             (t_seq_busy)
    );

    // Independent copy of the SSD1306 power-up stream.
    logic [7:0] ref_init [NUM_CMDS] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    function automatic logic [7:0] ref_byte(input int k);
        if (k == 0) return 8'h00;
        return ref_init[k-1];
    endfunction

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cnt = 0;
    int last_start_cyc = 0;
    int drop_cyc = 0;
    int saved_n = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every byte the controller latches must be the next one expected.
    always @(negedge clk) begin
        if (start) begin
            start_cnt++;
            last_start_cyc = cyc;
        end
        if (data_saved) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL byte_overflow: got data_in=%0h, expected no byte", data_in);
            end else begin
                check("stream_byte", data_in, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic push_stream(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(ref_byte(k));
    endtask

    task automatic wait_end(input int budget);
        int w;
        w = 0;
        while (!(done || error) && w < budget) begin
            tick();
            w++;
        end
    endtask

    // Controller model: one write transaction. nack_at = byte whose data_saved
    // coincides with NACK (ADDR_NACK = address NACK ~300 cycles in); abort_at
    // returns with busy still high before that byte is latched.
    task automatic ctrl_txn(input int gap_lo, input int gap_hi, input int nack_at, input int abort_at);
        int w;
        int gap;
        w = 0;
        saved_n = 0;
        while (!start && w < START_WAIT) begin
            tick();
            w++;
        end
        if (!start) begin
            checks++;
            errors++;
            $display("FAIL start_wait: got no start in %0d cycles, expected a start pulse", START_WAIT);
            return;
        end
        repeat ($urandom_range(1, 4)) tick();
        busy = 1'b1;
        if (nack_at == ADDR_NACK) begin
            repeat (300) tick();
            nack = 1'b1;
            tick();
            nack = 1'b0;
            repeat (40) tick();
            busy = 1'b0;
            drop_cyc = cyc;
            return;
        end
        gap = gap_lo;
        for (int k = 0; k <= NUM_CMDS + 1; k++) begin
            if (k == abort_at) return;
            gap = $urandom_range(gap_lo, gap_hi);
            repeat (gap) tick();
            if (!send_additional_data) break;
            data_saved = 1'b1;
            if (k == nack_at) nack = 1'b1;
            tick();
            data_saved = 1'b0;
            nack = 1'b0;
            saved_n++;
            if (k == nack_at) break;
        end
        repeat (gap) tick();
        busy = 1'b0;
        drop_cyc = cyc;
    endtask

    initial begin
        int t0, s0, k, w;
        reset = 1'b1; go = 1'b0; busy = 1'b0; nack = 1'b0; data_saved = 1'b0;
        t_go = 1'b0; t_busy = 1'b0;
        repeat (3) tick();

        check("rst_start", start, 0);
        check("rst_address", address_in, 8'h78);
        check("rst_data_in", data_in, 8'h00);
        check("rst_sad", send_additional_data, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_seq_busy", seq_busy, 0);
        reset = 1'b0;
        tick();

        // Watchdog: busy held high forever, error exactly TO_CYCLES after LAUNCH.
        t_go = 1'b1;
        tick();
        t_go = 1'b0;
        check("to_start", t_start, 1);
        t0 = cyc;
        tick();
        tick();
        t_busy = 1'b1;
        w = 0;
        while (!t_error && w < TO_CYCLES + 100) begin
            tick();
            w++;
        end
        check("to_latency", cyc - t0, TO_CYCLES);
        check("to_done", t_done, 0);
        check("to_sad", t_sad, 0);
        check("to_seq_busy", t_seq_busy, 0);

        // Nominal: 26 bytes at 720-cycle spacing, all ACKed.
        s0 = start_cnt;
        push_stream(NUM_CMDS + 1);
        pulse_go();
        check("nom_seq_busy", seq_busy, 1);
        ctrl_txn(720, 720, -1, -1);
        check("nom_saved", saved_n, NUM_CMDS + 1);
        check("nom_sad_low", send_additional_data, 0);
        check("nom_done_early", done, 0);
        wait_end(20);
        check("nom_done", done, 1);
        check("nom_error", error, 0);
        check("nom_seq_busy_end", seq_busy, 0);
        check("nom_starts", start_cnt - s0, 1);
        check("nom_queue", exp_q.size(), 0);

        // go while another master holds busy is ignored.
        s0 = start_cnt;
        busy = 1'b1;
        tick();
        pulse_go();
        repeat (30) tick();
        check("busy_go_starts", start_cnt - s0, 0);
        check("busy_go_seq_busy", seq_busy, 0);
        busy = 1'b0;
        tick();

`ifndef I2C_SEQ_RETRY_EN
        // Address NACK: no bytes latched, error after busy falls.
        pulse_go();
        check("anack_cleared", done, 0);
        ctrl_txn(720, 720, ADDR_NACK, -1);
        check("anack_error_early", error, 0);
        wait_end(20);
        repeat (50) tick();
        check("anack_error", error, 1);
        check("anack_done", done, 0);
        check("anack_seq_busy", seq_busy, 0);
        check("anack_sad", send_additional_data, 0);
        check("anack_data_in", data_in, 8'h00);

        // NACK coincident with a random byte's data_saved.
        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(0, NUM_CMDS);
            push_stream(k + 1);
            pulse_go();
            ctrl_txn(20, 60, k, -1);
            wait_end(20);
            check("rnack_error", error, 1);
            check("rnack_done", done, 0);
            check("rnack_sad", send_additional_data, 0);
            check("rnack_queue", exp_q.size(), 0);
        end
`else
        // Retry: NACK on attempt 1 only.
        push_stream(NUM_CMDS + 1);
        pulse_go();
        ctrl_txn(720, 720, ADDR_NACK, -1);
        t0 = drop_cyc;
        ctrl_txn(20, 60, -1, -1);
        // busy dropped after edge t0, so edge t0+1 is the first with busy=0.
        check("retry_gap", last_start_cyc - t0, 1025);
        wait_end(20);
        check("retry_done", done, 1);
        check("retry_error", error, 0);
        check("retry_queue", exp_q.size(), 0);

        // NACK on every attempt: ERROR after the 4th start.
        s0 = start_cnt;
        pulse_go();
        for (int a = 0; a < 4; a++) ctrl_txn(720, 720, ADDR_NACK, -1);
        wait_end(20);
        check("exh_error", error, 1);
        check("exh_done", done, 0);
        check("exh_starts", start_cnt - s0, 4);
        repeat (1100) tick();
        check("exh_no_more", start_cnt - s0, 4);
`endif

        // Reset in the middle of STREAM (idx=7), then a clean restart.
        push_stream(7);
        pulse_go();
        ctrl_txn(20, 60, -1, 7);
        reset = 1'b1;
        tick();
        check("mid_rst_start", start, 0);
        check("mid_rst_data_in", data_in, 8'h00);
        check("mid_rst_sad", send_additional_data, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_seq_busy", seq_busy, 0);
        reset = 1'b0;
        busy = 1'b0;
        tick();
        check("mid_rst_queue", exp_q.size(), 0);
        push_stream(NUM_CMDS + 1);
        pulse_go();
        ctrl_txn(20, 60, -1, -1);
        wait_end(20);
        check("restart_done", done, 1);
        check("restart_error", error, 0);
        check("restart_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Drives the existing I2C_Controller to send a power-up command stream to the SSD1306 OLED at write address 0x78.
- Sends a single write transaction: address, control byte 0x00, then NUM_CMDS bytes from a command ROM, chained with send_additional_data.
- Reports done/error to the GPU top level and gates further display traffic until done.

Parameters:
- DEV_ADDR, 8'h78, 8-bit write address driven on address_in.
- NUM_CMDS, 25, number of ROM command bytes (1..64).
- TIMEOUT_CYCLES, 2_700_000, watchdog limit in clk cycles (100 ms at 27 MHz).
- MAX_RETRIES, 3, retry attempts; used only with I2C_SEQ_RETRY_EN.

Ports:
- clk  in  1  system clock (27 MHz)
- reset  in  1  synchronous, active-high reset
- go  in  1  level or pulse; a rising condition in IDLE launches the sequence
- busy  in  1  from I2C_Controller, high while a transaction is in progress
- NACK  in  1  from I2C_Controller, one-cycle pulse on missing ACK
- data_saved  in  1  from I2C_Controller, one-cycle pulse when data_in has been latched into the shift register
- start  out  1  to I2C_Controller, one-cycle start pulse
- address_in  out  8  to I2C_Controller
- data_in  out  8  to I2C_Controller, byte currently offered
- send_additional_data  out  1  to I2C_Controller, high while data_in holds an unsent byte
- done  out  1  sticky, sequence completed with no NACK
- error  out  1  sticky, NACK or timeout, retries exhausted
- seq_busy  out  1  high in every state except IDLE, DONE and ERROR

Behaviour:
- Reset values: start=0, address_in=DEV_ADDR, data_in=8'h00, send_additional_data=0, done=0, error=0, seq_busy=0, idx=0, state=IDLE. Reset mid-transaction aborts immediately; the controller is expected to be reset by the same signal.
- Byte index idx counts 0..NUM_CMDS. Byte 0 is the control byte 0x00; byte k (k≥1) is ROM[k-1]. The last byte is idx = NUM_CMDS.
- IDLE: on go=1 and busy=0, load data_in=0x00, set send_additional_data=1 and idx=0, then go to LAUNCH. go while busy=1 is ignored.
- LAUNCH: assert start for exactly 1 cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for busy=1, then go to STREAM. If busy does not rise within 16 cycles, treat as a fault.
- STREAM: on a data_saved pulse, update outputs the next cycle:
  - if idx < NUM_CMDS: idx++, data_in = byte idx+1, send_additional_data stays 1.
  - if idx = NUM_CMDS: send_additional_data=0, go to WAIT_DONE.
  - At most one byte advances per data_saved pulse. data_saved while not in STREAM is ignored.
- WAIT_DONE: on busy falling to 0, go to DONE and set done=1.
- DONE and ERROR are terminal. A new go re-runs the sequence and clears done/error in the cycle IDLE re-entry would occur.
- Fault conditions:
  - A NACK pulse in any active state is latched into a fault flag; the sequence continues to wait for busy=0, then resolves as a fault.
  - The watchdog counter runs from LAUNCH. Reaching TIMEOUT_CYCLES is a fault taken immediately.
- Fault resolution: go to ERROR and set error=1; send_additional_data=0.
- NACK in the same cycle as data_saved: the NACK wins; idx still advances, but the result is a fault.
- ROM index never exceeds NUM_CMDS-1; there is no wrap-around.

Optional Feature:
- Macro: I2C_SEQ_RETRY_EN.
  - Defined: a fault goes to BACKOFF and waits 1024 cycles with busy=0. It then increments retry_cnt and re-enters LAUNCH from idx=0. ERROR is taken only when retry_cnt = MAX_RETRIES. retry_cnt resets on reset and on entry from IDLE.
  - Undefined: a fault goes directly to ERROR; no retry_cnt register exists.

Decomposition:
- Package i2c_seq_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT_BUSY, STREAM, WAIT_DONE, BACKOFF, DONE, ERROR)
  - CTRL_CMD_STREAM = 8'h00
  - the SSD1306 init byte array constant (0xAE, 0xD5, 0x80, 0xA8, 0x3F, … 0xAF)
  - BACKOFF_CYCLES = 1024
- Sub-module i2c_cmd_rom: combinational index to byte from the package constant, so alternative panels can reuse the sequencer.

Test Plan:
- Nominal: a behavioural I2C model pulses data_saved every 720 cycles and ACKs all bytes; pulse go → one start pulse, data_in sequence 0x00, 0xAE, 0xD5, …, 0xAF (26 bytes), send_additional_data falls after the 26th data_saved, done=1 after busy falls, error=0.
- NACK on address (pulse at cycle 300, macro off) → no further data_in change after busy falls, error=1, done=0, seq_busy=0.
- Retry (macro on): NACK on attempt 1 only → second start exactly 1024 cycles after busy falls, data_in restarts at 0x00, done=1, error=0; NACK on all 4 attempts → error=1 after the 4th start.
- Timeout: model holds busy=1 forever → error=1 exactly TIMEOUT_CYCLES (parameter overridden to 5000) after LAUNCH.
- go asserted while busy=1 → no start issued; reset asserted mid-STREAM (idx=7) → next cycle all outputs at reset values, and a new go restarts at 0x00.
